// File: rtl/mag_peak_pkg.sv
// Shared types and constants for the magnitude peak detector.
package mag_peak_pkg;

  // Quant (fractional) field width, shared with the magnitude stage.
  localparam int unsigned QB = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} mp_state_t;

endpackage

// File: rtl/mag_peak_detect_if.sv
// Sample-in / result-out bus of the magnitude peak detector.
interface mag_peak_detect_if
  import mag_peak_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned IDX_W = 10
) ();

  // Frame control
  logic [IDX_W-1:0] frame_len;
  logic [W-1:0]     thr;
  logic             flush;

  // Sample stream
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     mag;
  logic [QB-1:0]    mag_quant;

  // Per-frame result
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     peak_mag;
  logic [IDX_W-1:0] peak_idx;
  logic [QB-1:0]    peak_quant;
  logic [IDX_W:0]   above_cnt;
  logic             quant_err;

  // Producer / consumer side
  modport master (
    output frame_len, thr, flush, in_valid, mag, mag_quant, out_ready,
    input  in_ready, out_valid, peak_mag, peak_idx, peak_quant, above_cnt, quant_err
  );

  // Detector side
  modport slave (
    input  frame_len, thr, flush, in_valid, mag, mag_quant, out_ready,
    output in_ready, out_valid, peak_mag, peak_idx, peak_quant, above_cnt, quant_err
  );

endinterface

// File: rtl/mag_peak_detect.sv
// Frame-based peak search: per frame reports the largest magnitude, the index of its
// first occurrence, the first sample's quant bits, and the count of samples >= threshold.
module mag_peak_detect
  import mag_peak_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned IDX_W = 10
) (
  input logic              clk,
  input logic              rst,
  mag_peak_detect_if.slave bus
);

  // above_cnt ceiling: a full frame of 2**IDX_W samples
  localparam logic [IDX_W:0] AboveMax = {1'b1, {IDX_W{1'b0}}};

  mp_state_t        state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] len_q;
  logic [W-1:0]     thr_q;
  logic [W-1:0]     peak_mag_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic [QB-1:0]    peak_quant_q;
  logic [IDX_W:0]   above_cnt_q;
  logic             quant_err_q;

  logic in_ready;
  logic out_valid;
  logic accept;

  assign accept = bus.in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (bus.frame_len == '0) ? ST_DONE : ST_ACC;
      ST_ACC:  if (accept && (cnt_q == len_q)) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = !rst && ((state_q == ST_IDLE) || (state_q == ST_ACC));
    out_valid = (state_q == ST_DONE);
  end

  // Compare/update datapath; result regs persist until the next frame's first accept
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      len_q        <= '0;
      thr_q        <= '0;
      peak_mag_q   <= '0;
      peak_idx_q   <= '0;
      peak_quant_q <= '0;
      above_cnt_q  <= '0;
      quant_err_q  <= 1'b0;
    end else if (bus.flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        len_q        <= bus.frame_len;
        thr_q        <= bus.thr;
        peak_mag_q   <= bus.mag;
        peak_idx_q   <= '0;
        peak_quant_q <= bus.mag_quant;
        above_cnt_q  <= {{IDX_W{1'b0}}, (bus.mag >= bus.thr)};
        quant_err_q  <= 1'b0;
        cnt_q        <= IDX_W'(1);
      end else begin
        // Strict compare so ties keep the earlier index
        if (bus.mag > peak_mag_q) begin
          peak_mag_q <= bus.mag;
          peak_idx_q <= cnt_q;
        end
        if ((bus.mag >= thr_q) && (above_cnt_q != AboveMax)) begin
          above_cnt_q <= above_cnt_q + 1'b1;
        end
        if (bus.mag_quant != peak_quant_q) begin
          quant_err_q <= 1'b1;
        end
        if (cnt_q != len_q) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_idx   = peak_idx_q;
  assign bus.peak_quant = peak_quant_q;
  assign bus.above_cnt  = above_cnt_q;
  assign bus.quant_err  = quant_err_q;

endmodule

// File: tb/tb_mag_peak_detect.sv
// Directed bench for mag_peak_detect with a result scoreboard fed by a frame model.
module tb_mag_peak_detect;

  localparam int unsigned W     = 16;
  localparam int unsigned IDX_W = 10;

  typedef struct packed {
    logic [W-1:0]     mag;
    logic [IDX_W-1:0] idx;
    logic [5:0]       q;
    logic [IDX_W:0]   cnt;
    logic             qerr;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  res_t        exp_q[$];
  logic [15:0] smag[$];
  logic [5:0]  sq[$];
  int          tests = 0;
  int          fails = 0;
  int          stalls;

  mag_peak_detect_if #(.W(W), .IDX_W(IDX_W)) bus ();

  mag_peak_detect #(.W(W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: observed no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model the frame held in smag/sq, optionally queue its result, then drive the first
  // n_drive samples. Ends on the negedge after the last accept with in_valid low.
  task automatic drive_frame(input logic [IDX_W-1:0] flen, input logic [W-1:0] t,
                             input int n_drive, input bit push);
    res_t e;
    int   above;
    e.mag = smag[0];
    e.idx = '0;
    e.q   = sq[0];
    e.qerr = 1'b0;
    above = 0;
    for (int i = 0; i < smag.size(); i++) begin
      if (i > 0 && smag[i] > e.mag) begin
        e.mag = smag[i];
        e.idx = IDX_W'(i);
      end
      if (smag[i] >= t) above++;
      if (sq[i] != sq[0]) e.qerr = 1'b1;
    end
    e.cnt = (IDX_W+1)'(above);
    if (push) exp_q.push_back(e);

    stalls = 0;
    bus.frame_len = flen;
    bus.thr       = t;
    for (int i = 0; i < n_drive; i++) begin
      int g;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.mag       = smag[i];
      bus.mag_quant = sq[i];
      // Control changes after the first accept must not affect this frame
      if (i == 1) begin
        bus.frame_len = IDX_W'($urandom);
        bus.thr       = W'($urandom);
      end
      g = 0;
      while (!bus.in_ready && g < 50) begin
        @(negedge clk);
        g++;
        stalls++;
      end
      if (g >= 50) chk("in_ready_timeout", bus.in_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mag      = W'($urandom);
  endtask

  // Called on the negedge right after the last accept: result must already be valid.
  task automatic check_result(input bit keep_ready);
    res_t e;
    chk("out_valid_latency", bus.out_valid, 1);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("peak_mag", bus.peak_mag, e.mag);
      chk("peak_idx", bus.peak_idx, e.idx);
      chk("peak_quant", bus.peak_quant, e.q);
      chk("above_cnt", bus.above_cnt, e.cnt);
      chk("quant_err", bus.quant_err, e.qerr);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = keep_ready;
      chk("out_valid_drop", bus.out_valid, 0);
      chk("in_ready_after_hs", bus.in_ready, 1);
      chk("peak_mag_held", bus.peak_mag, e.mag);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_peak_mag"}, bus.peak_mag, 0);
    chk({tag, "_peak_idx"}, bus.peak_idx, 0);
    chk({tag, "_peak_quant"}, bus.peak_quant, 0);
    chk({tag, "_above_cnt"}, bus.above_cnt, 0);
    chk({tag, "_quant_err"}, bus.quant_err, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.frame_len = '0;
    bus.thr       = '0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mag       = '0;
    bus.mag_quant = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // 1: basic frame, tie at 20 keeps index 1
    smag = '{16'd5, 16'd20, 16'd7, 16'd20};
    sq   = '{6'd8, 6'd8, 6'd8, 6'd8};
    drive_frame(10'd3, 16'd10, 4, 1'b1);
    check_result(1'b0);
    chk("t1_peak_mag_const", bus.peak_mag, 20);
    chk("t1_peak_idx_const", bus.peak_idx, 1);
    chk("t1_above_const", bus.above_cnt, 2);

    // 2: single-sample frame, result held under backpressure
    smag = '{16'h00FF};
    sq   = '{6'd17};
    drive_frame(10'd0, 16'h0100, 1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("t2_hold_valid", bus.out_valid, 1);
      chk("t2_hold_ready", bus.in_ready, 0);
      chk("t2_hold_mag", bus.peak_mag, 16'h00FF);
      @(negedge clk);
    end
    check_result(1'b0);

    // 3: quant mismatch inside the frame
    smag = '{16'd40, 16'd30, 16'd50};
    sq   = '{6'd8, 6'd9, 6'd8};
    drive_frame(10'd2, 16'd35, 3, 1'b1);
    check_result(1'b0);

    // 4: flush mid-frame, then a clean frame
    smag = '{16'd100, 16'd200, 16'd300, 16'd400};
    sq   = '{6'd1, 6'd1, 6'd1, 6'd1};
    drive_frame(10'd3, 16'd0, 2, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_no_valid", bus.out_valid, 0);
      chk("t4_ready", bus.in_ready, 1);
      @(negedge clk);
    end
    smag = '{16'd3, 16'd1};
    sq   = '{6'd2, 6'd2};
    drive_frame(10'd1, 16'd2, 2, 1'b1);
    check_result(1'b0);

    // Flush discards a pending result even with out_ready high
    smag = '{16'd9};
    sq   = '{6'd4};
    drive_frame(10'd0, 16'd1, 1, 1'b0);
    chk("flush_done_valid", bus.out_valid, 1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_done_drop", bus.out_valid, 0);

    // Flush beats a same-cycle accept in IDLE: result regs untouched
    bus.in_valid = 1'b1;
    bus.mag      = 16'd500;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    chk("flush_accept_valid", bus.out_valid, 0);
    chk("flush_accept_mag", bus.peak_mag, 16'd9);

    // 5: maximum frame, back-to-back, out_ready held high
    smag.delete();
    sq.delete();
    for (int i = 0; i < 1024; i++) begin
      smag.push_back(16'($urandom));
      sq.push_back(6'd3);
    end
    bus.out_ready = 1'b1;
    drive_frame(10'd1023, 16'd0, 1024, 1'b1);
    chk("t5_no_stalls", stalls, 0);
    check_result(1'b1);
    chk("t5_above_const", bus.above_cnt, 1024);
    bus.out_ready = 1'b0;

    // 6: reset mid-frame
    smag = '{16'd50, 16'd60, 16'd70, 16'd80};
    sq   = '{6'd5, 6'd5, 6'd5, 6'd5};
    drive_frame(10'd3, 16'd1, 2, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check_zero("t6_mid");
    rst = 1'b0;
    #1;
    chk("t6_ready_after", bus.in_ready, 1);

    // Reset while a result is pending
    smag = '{16'd7};
    sq   = '{6'd5};
    drive_frame(10'd0, 16'd1, 1, 1'b0);
    chk("t6_done_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_done_rst_ready", bus.in_ready, 0);
    @(negedge clk);
    check_zero("t6_done");
    rst = 1'b0;
    #1;
    chk("t6_done_ready_after", bus.in_ready, 1);

    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
